sad_result_uart_tx: RTL

- UART transmitter returning the SAD processor's match coordinates to the host over TxD. It is the outbound counterpart of the RxD image-loading link.
- Accepts one (x, y) result per valid pulse from the core and packs it into a fixed 3-byte record (optionally preceded by a header byte).
- Serializes the record as 8N1 frames, LSB first, at CLKS_PER_BIT clocks per bit; this is the same bit timing the receive side uses.

---
 rtl/sad_result_uart_tx.sv | 76 +++++++
 1 files changed

// File: rtl/sad_result_uart_tx.sv
// sad_result_uart_tx: 8N1 serializer sending SAD match coordinates (x, y) to the host as a 3- or 4-byte record
module sad_result_uart_tx #(
    parameter int         CLKS_PER_BIT = 1,
    parameter bit         HEADER_EN    = 1'b0,
    parameter logic [7:0] HEADER       = 8'hA5
) (
    input  logic       clock,
    input  logic       notReset,
    input  logic       valid,
    input  logic [9:0] x_in,
    input  logic [8:0] y_in,
    output logic       TxD,
    output logic       busy,
    output logic       done,
    output logic       overrun
);
    localparam logic [1:0] LAST = HEADER_EN ? 2'd3 : 2'd2;
    localparam int         CW   = $clog2(CLKS_PER_BIT + 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t        state, next_state;
    logic [CW-1:0] cnt;
    logic [2:0]    bit_idx, bit_nxt;
    logic [1:0]    byte_idx;
    logic [31:0]   rec;
    logic [23:0]   payload;
    logic          bit_end, tx_nxt, busy_nxt, done_nxt, overrun_nxt;

    assign bit_end = cnt == CW'(CLKS_PER_BIT - 1);
    assign payload = {5'b0, y_in, x_in};

    always_ff @(posedge clock or negedge notReset)
        if (!notReset) state <= IDLE;
        else           state <= next_state;

    always_comb begin
        next_state = state;
        case (state)
            IDLE:  next_state = valid ? START : IDLE;
            START: next_state = bit_end ? DATA : START;
            DATA:  next_state = (bit_end && bit_idx == 3'd7) ? STOP : DATA;
            STOP:  next_state = bit_end ? (byte_idx == LAST ? IDLE : START) : STOP;
        endcase
    end

    // outputs are computed one cycle ahead from next_state so they can be registered
    always_comb begin
        bit_nxt     = state == DATA ? bit_idx + {2'b0, bit_end} : 3'd0;
        tx_nxt      = next_state == START ? 1'b0 : next_state == DATA ? rec[{byte_idx, bit_nxt}] : 1'b1;
        busy_nxt    = next_state != IDLE;
        done_nxt    = state == STOP && next_state == IDLE;
        overrun_nxt = valid && state != IDLE;
    end

    always_ff @(posedge clock or negedge notReset)
        if (!notReset) begin
            cnt      <= '0;
            bit_idx  <= 3'd0;
            byte_idx <= 2'd0;
            rec      <= 32'd0;
            TxD      <= 1'b1;
            busy     <= 1'b0;
            done     <= 1'b0;
            overrun  <= 1'b0;
        end else begin
            cnt      <= (state == IDLE || bit_end) ? '0 : cnt + 1'b1;
            bit_idx  <= bit_nxt;
            byte_idx <= state == IDLE ? 2'd0 : (state == STOP && bit_end) ? byte_idx + 1'b1 : byte_idx;
            rec      <= (state == IDLE && valid) ? (HEADER_EN ? {payload, HEADER} : {8'h00, payload}) : rec;
            TxD      <= tx_nxt;
            busy     <= busy_nxt;
            done     <= done_nxt;
            overrun  <= overrun_nxt;
        end
endmodule
